// File: rtl/fmap_writer.sv
// fmap_writer: write stage for the six-channel feature-map RAM bank.
// Accepts raster-ordered 6-channel pixels over valid/ready. For each accepted
// beat it registers a shared write address, per-channel write enables and the
// write data. After the last pixel of the frame it pulses done.
// Optional feature: define FMAP_RELU_EN to clamp negative samples to zero
// before storage. The default build (macro undefined) stores samples unmodified.
module fmap_writer #(
  parameter int WIDTH  = 126,
  parameter int HEIGHT = 126,
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [5:0]        ch_mask_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [47:0]       in_data_i,
  output logic [ADDR_W-1:0] addr_write_o,
  output logic [5:0]        we_o,
  output logic [47:0]       wr_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_e;

  state_e state_q, state_d;

  logic [5:0]        mask_q, mask_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [5:0]        we_q, we_d;
  logic [47:0]       data_q, data_d;
  logic              done_q, done_d;

  logic beat;
  logic last_beat;

  // Storage format of one pixel: optionally rectify each signed 8-bit lane.
  function automatic logic [47:0] store_fmt(input logic [47:0] d);
    logic [47:0] r;
`ifdef FMAP_RELU_EN
    for (int i = 0; i < 6; i++) begin
      r[8*i +: 8] = d[8*i+7] ? 8'h00 : d[8*i +: 8];
    end
`else
    r = d;
`endif
    return r;
  endfunction

  assign beat      = in_valid_i && in_ready_o;
  assign last_beat = beat && (col_q == LAST_COL) && (row_q == LAST_ROW);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a frame runs until the last pixel, then one flush cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i)   state_d = S_RUN;
      S_RUN:   if (last_beat) state_d = S_FLUSH;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: handshake, busy flag and the done pulse request.
  always_comb begin
    in_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE:  ;
      S_RUN: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      S_FLUSH: begin
        busy_o = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: mask capture, raster counters and write bus staging.
  always_comb begin
    mask_d = mask_q;
    col_d  = col_q;
    row_d  = row_q;
    idx_d  = idx_q;
    addr_d = addr_q;
    data_d = data_q;
    we_d   = 6'h00;

    if (state_q == S_IDLE && start_i) begin
      mask_d = ch_mask_i;
      col_d  = '0;
      row_d  = '0;
      idx_d  = '0;
    end

    if (beat) begin
      addr_d = idx_q;
      we_d   = mask_q;
      data_d = store_fmt(in_data_i);
      // The index holds on the final pixel so it never passes WIDTH*HEIGHT-1.
      if (!last_beat) begin
        idx_d = idx_q + ADDR_W'(1);
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

  // Datapath registers; reset mid-frame abandons the frame without done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      idx_q  <= '0;
      addr_q <= '0;
      we_q   <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      col_q  <= col_d;
      row_q  <= row_d;
      idx_q  <= idx_d;
      addr_q <= addr_d;
      we_q   <= we_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end

  assign addr_write_o = addr_q;
  assign we_o         = we_q;
  assign wr_data_o    = data_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_fmap_writer.sv
// Self-checking bench for fmap_writer on a 4x3 frame. Expected writes are
// queued when a beat is accepted and compared when the write appears.
// Works with and without FMAP_RELU_EN defined.
module tb_fmap_writer;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int ADDR_W = 14;
  localparam int NPIX   = WIDTH * HEIGHT;
`ifdef FMAP_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic [5:0]        ch_mask_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [47:0]       in_data_i;
  logic [ADDR_W-1:0] addr_write_o;
  logic [5:0]        we_o;
  logic [47:0]       wr_data_o;
  logic              busy_o;
  logic              done_o;

  fmap_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ch_mask_i(ch_mask_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .addr_write_o(addr_write_o), .we_o(we_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [47:0] d;
    logic [47:0] e;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [5:0]        we;
    logic [47:0]       data;
  } exp_wr_t;

  vec_t    tbl[NPIX];
  exp_wr_t sb[$];
  exp_wr_t mon_e;

  int       n_vec    = 0;
  int       n_miss   = 0;
  int       beat_idx = 0;
  int       done_cnt = 0;
  logic [5:0] exp_mask = 6'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every asserted write must match the oldest queued beat.
  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (we_o != 6'h00) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(we_o), 64'h0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 64'(addr_write_o), 64'(mon_e.addr));
        check("wr_we",   64'(we_o),         64'(mon_e.we));
        check("wr_data", 64'(wr_data_o),    64'(mon_e.data));
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic v, input logic [47:0] d, input logic [47:0] ed,
                       input logic st, input logic [5:0] m, input logic exp_rdy,
                       input string tag);
    logic acc;
    in_valid_i = v;
    in_data_i  = d;
    start_i    = st;
    ch_mask_i  = m;
    check({tag, "_in_ready"}, 64'(in_ready_o), 64'(exp_rdy));
    acc = v && in_ready_o;
    if (acc) begin
      if (exp_mask != 6'h00)
        sb.push_back('{addr: ADDR_W'(beat_idx), we: exp_mask, data: ed});
      beat_idx++;
    end
    @(posedge clk_i);
    #1;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    if (!acc || exp_mask == 6'h00) check({tag, "_we_zero"}, 64'(we_o), 64'h0);
  endtask

  task automatic begin_frame(input logic [5:0] m, input string tag);
    cycle(1'b0, 48'h0, 48'h0, 1'b1, m, 1'b0, {tag, "_start"});
    exp_mask = m;
    beat_idx = 0;
    check({tag, "_busy_up"},  64'(busy_o),     64'h1);
    check({tag, "_ready_up"}, 64'(in_ready_o), 64'h1);
  endtask

  // Full-rate beats; ch_mask_i is driven with junk to show it is ignored.
  task automatic run_beats(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      int k;
      k = beat_idx;
      cycle(1'b1, tbl[k].d, tbl[k].e, 1'b0, ~exp_mask, 1'b1, tag);
    end
  endtask

  // After the last beat: FLUSH now, done next cycle, then quiet.
  task automatic frame_tail(input string tag, input int done_before);
    check({tag, "_flush_busy"}, 64'(busy_o), 64'h1);
    check({tag, "_flush_done"}, 64'(done_o), 64'h0);
    cycle(1'b1, 48'h0, 48'h0, 1'b0, 6'h00, 1'b0, {tag, "_flush"});
    check({tag, "_done_pulse"}, 64'(done_o), 64'h1);
    check({tag, "_busy_down"},  64'(busy_o), 64'h0);
    cycle(1'b0, 48'h0, 48'h0, 1'b0, 6'h00, 1'b0, {tag, "_idle"});
    check({tag, "_done_low"},   64'(done_o), 64'h0);
    check({tag, "_done_count"}, 64'(done_cnt - done_before), 64'h1);
    check({tag, "_sb_empty"},   64'(sb.size()), 64'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready_o),   64'h0);
    check({tag, "_addr"},     64'(addr_write_o), 64'h0);
    check({tag, "_we"},       64'(we_o),         64'h0);
    check({tag, "_wr_data"},  64'(wr_data_o),    64'h0);
    check({tag, "_busy"},     64'(busy_o),       64'h0);
    check({tag, "_done"},     64'(done_o),       64'h0);
  endtask

  initial begin
    int d0;
    int guard;
    int ph;

    // Pixel table: two rows exercise the sign-bit rule on every lane pattern.
    tbl[0].d = 48'h80FF7F0012C3;
    tbl[0].e = RELU ? 48'h00007F001200 : 48'h80FF7F0012C3;
    tbl[1].d = 48'h017F80FE4000;
    tbl[1].e = RELU ? 48'h017F00004000 : 48'h017F80FE4000;
    for (int k = 2; k < NPIX; k++) begin
      tbl[k].d = {6{8'(k * 5)}};
      tbl[k].e = {6{8'(k * 5)}};
    end

    rst_ni = 1'b0; start_i = 1'b0; ch_mask_i = 6'h00;
    in_valid_i = 1'b0; in_data_i = 48'h0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Idle: valid without start is never accepted.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, tbl[0].d, tbl[0].e, 1'b0, 6'h3F, 1'b0, "idle");

    // Full frame, all channels, valid held high.
    d0 = done_cnt;
    begin_frame(6'h3F, "full");
    run_beats(NPIX, "full");
    frame_tail("full", d0);

    // Stalls: valid pattern 1,0,0,1,0,0...
    d0 = done_cnt;
    begin_frame(6'h3F, "stall");
    guard = 0;
    ph = 0;
    while (beat_idx < NPIX && guard < 100) begin
      int k;
      k = beat_idx;
      cycle((ph % 3) == 0, tbl[k].d, tbl[k].e, 1'b0, 6'h00, 1'b1, "stall");
      ph++;
      guard++;
    end
    check("stall_budget", 64'(beat_idx), 64'(NPIX));
    frame_tail("stall", d0);

    // Partial mask with a second start pulse mid-frame.
    d0 = done_cnt;
    begin_frame(6'b000101, "mask");
    run_beats(5, "mask");
    cycle(1'b1, tbl[5].d, tbl[5].e, 1'b1, 6'h3F, 1'b1, "mask_restart");
    run_beats(NPIX - 6, "mask");
    frame_tail("mask", d0);

    // Zero mask: frame completes, no write enables.
    d0 = done_cnt;
    begin_frame(6'h00, "zero");
    run_beats(NPIX, "zero");
    frame_tail("zero", d0);

    // Reset after beat 5: asynchronous clear, no done, clean restart.
    begin_frame(6'h3F, "rst");
    run_beats(5, "rst");
    @(negedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_no_done", 64'(done_cnt - d0), 64'h0);
    check("rst_idle_busy", 64'(busy_o), 64'h0);
    d0 = done_cnt;
    begin_frame(6'h3F, "restart");
    run_beats(NPIX, "restart");
    frame_tail("restart", d0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fmap_writer.md
# fmap_writer

Upstream write stage for the six-channel feature-map RAM bank. It accepts a raster-ordered stream of 6-channel pixels from the convolution datapath over a valid/ready handshake. For each accepted pixel it generates the shared write address and per-channel write enables, then signals frame completion so the downstream reader can start.

## Interface
- `WIDTH`, default 126: feature-map columns.
- `HEIGHT`, default 126: feature-map rows. `WIDTH*HEIGHT` must be ≤ 2^ADDR_W.
- `ADDR_W`, default 14: write address width.
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse; begins a frame. Sampled only in IDLE.
- `ch_mask`  in  6: channel write mask, captured on accepted `start`. Bit0 = channel 1.
- `in_valid`  in  1: `in_data` holds a pixel.
- `in_ready`  out  1: writer accepts a pixel this cycle.
- `in_data`  in  48: six signed 8-bit samples, channel 1 in [7:0] … channel 6 in [47:40].
- `addr_write`  out  ADDR_W: write address, shared by all six channel RAMs.
- `we`  out  6: per-channel write enables; bit i drives channel i+1.
- `wr_data`  out  48: write data, same packing as `in_data`.
- `busy`  out  1: high from accepted `start` until `done`.
- `done`  out  1: one-cycle pulse after the last pixel's write cycle.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE:
  - `in_ready`=0; `in_valid` is ignored.
  - On `start`: capture `ch_mask`, clear `col`/`row`/`addr` counters, go to RUN.
- RUN:
  - `in_ready`=1.
  - Beat accepted when `in_valid && in_ready`.
  - Per accepted beat, registered next cycle: `addr_write` = current pixel index; `wr_data` = `in_data` (see Configuration); `we` = captured mask.
  - Then the pixel index increments; `col` wraps at WIDTH-1 to 0 and increments `row`.
  - On the beat with `row`=HEIGHT-1 and `col`=WIDTH-1, go to FLUSH.
- FLUSH:
  - `in_ready`=0; the last write is on the bus this cycle.
  - Next cycle: `done`=1, `busy`=0, return to IDLE.
- Cycles with no accepted beat drive `we`=0; `addr_write`/`wr_data` hold their previous values.
- `start` during RUN/FLUSH is ignored; `ch_mask` changes mid-frame have no effect.
- `ch_mask`=0: the frame still runs to completion with `we` never asserted; `done` still pulses.
- Pixel index = `row*WIDTH+col`, kept as an incrementing counter (no multiplier); never exceeds WIDTH*HEIGHT-1.
- Reset mid-frame:
  - Immediate return to IDLE.
  - All outputs go to reset values.
  - A partial frame is abandoned without `done`.

## Timing
- Reset values: `in_ready`=0, `addr_write`=0, `we`=0, `wr_data`=0, `busy`=0, `done`=0; state IDLE.
- `start` at cycle t: `busy`=1 and `in_ready`=1 from cycle t+1.
- Write latency is one cycle: beat accepted at t gives `we`/`addr_write`/`wr_data` valid at t+1, consumed by RAM at edge t+2.
- Full-rate throughput is one pixel per cycle. Back-to-back beats produce consecutive addresses with no bubbles.
- Last beat at t: FLUSH at t+1 (last write on bus), `done` at t+2.
- Earliest next `start` is accepted at t+2, the same cycle as `done`, because the state is IDLE then.
- `in_valid` may deassert at any time; counters hold.

## Configuration
- `FMAP_RELU_EN` defined: each 8-bit lane of `wr_data` = 0 if its sign bit is set, else the input value (ReLU applied before storage). Adds no latency.
- `FMAP_RELU_EN` undefined: `wr_data` = `in_data` unmodified.

## Test plan
- Reset/idle (WIDTH=4, HEIGHT=3): after reset all outputs are 0. `in_valid`=1 without `start` → `in_ready`=0, `we`=0 throughout.
- Full frame, mask 6'h3F, `in_valid` held high:
  - 12 writes with `addr_write` 0..11 on consecutive cycles, `we`=6'h3F each.
  - `done` pulses exactly 2 cycles after the 12th beat.
- Stalls: `in_valid` toggled 1,0,0,1,…:
  - Addresses still 0..11 with no gaps or repeats.
  - `we`=0 in every cycle following a non-accepted cycle.
- Mask 6'b000101 with `start` asserted again mid-frame → only `we[0]` and `we[2]` ever high; the second `start` is ignored; exactly one `done`.
- ReLU: `in_data` lane values 8'h80, 8'hFF, 8'h7F, 8'h00:
  - With `FMAP_RELU_EN` defined → `wr_data` lanes 0, 0, 7F, 00.
  - Without it → the values pass unchanged.
- Reset asserted after beat 5:
  - Outputs return to 0 asynchronously; no `done`.
  - A new `start` restarts from `addr_write`=0.
